// File: rtl/dtree_vote_filter.sv
// -----------------------------------------------------------------------------
// dtree_vote_filter
//
// Majority-vote smoother placed after the combinational decision-tree
// classifier. It keeps a sliding window of the last WIN labels and a count per
// class. Once the window is full, every accepted label starts a scan over the
// class counts, and the winner is offered on the output port. A tie goes to the
// lowest class index. If every count is zero, meaning all labels in the window
// were out of range, the result is class 0 with 0 votes.
//
// Optional feature macro: DTREE_VOTE_CONF_EN
//   Defined   : the out_votes port exists and carries the winner's vote count,
//               latched at the end of the scan.
//   Undefined : out_votes is absent. The best-count comparator still steers
//               out_class.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   in_class carries a label this cycle
//   in_class   label from the tree stage (CLASS_W bits)
//   in_ready   block can accept a label (IDLE only)
//   in_flush   clears window, fill, counts and running best (ignored in reset)
//   out_valid  out_class holds a vote result
//   out_ready  consumer accepts the result
//   out_class  majority class
//   out_err    sticky: an out-of-range label was accepted (cleared by reset)
//   out_votes  winner's vote count (DTREE_VOTE_CONF_EN only)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A source that raises valid keeps it and its data stable until that
// edge. Ready may depend only on registered state.
// -----------------------------------------------------------------------------
module dtree_vote_filter #(
  parameter int NUM_CLASSES = 10,
  parameter int WIN         = 5,
  parameter int CLASS_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [CLASS_W-1:0] in_class,
  output logic               in_ready,
  input  logic               in_flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLASS_W-1:0] out_class,
  output logic               out_err
`ifdef DTREE_VOTE_CONF_EN
  ,
  output logic [$clog2(WIN+1)-1:0] out_votes
`endif
);

  localparam int CNT_W = $clog2(WIN+1);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

  state_t             state_q;
  logic [CLASS_W-1:0] win_q [WIN];
  logic [CNT_W-1:0]   fill_q;
  logic [CNT_W-1:0]   cnt_q [NUM_CLASSES];
  logic [CLASS_W-1:0] scan_idx_q;
  logic [CLASS_W-1:0] best_cls_q;
  logic [CNT_W-1:0]   best_cnt_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [CLASS_W-1:0] out_class_q;
  logic               out_err_q;

  function automatic logic is_legal(input logic [CLASS_W-1:0] c);
    return 32'(c) < 32'(NUM_CLASSES);
  endfunction

  logic                   accept;
  logic                   full;
  logic                   new_legal;
  logic [CLASS_W-1:0]     old_cls;
  logic                   old_legal;
  logic [NUM_CLASSES-1:0] inc_hit;
  logic [NUM_CLASSES-1:0] dec_hit;
  logic [CNT_W-1:0]       scan_cnt;
  logic                   scan_better;
  logic                   scan_last;
  logic [CLASS_W-1:0]     final_cls;
  logic [CNT_W-1:0]       final_cnt;

  assign accept    = in_valid & in_ready_q;
  assign full      = (fill_q == CNT_W'(WIN));
  assign new_legal = is_legal(in_class);
  assign old_cls   = win_q[WIN-1];
  // The oldest entry is only evicted once the window is full. Illegal labels
  // were never counted, so they are never decremented.
  assign old_legal = full & is_legal(old_cls);

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      inc_hit[i] = new_legal && (in_class == CLASS_W'(i));
      dec_hit[i] = old_legal && (old_cls == CLASS_W'(i));
    end
  end

  always_comb begin
    scan_cnt = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (scan_idx_q == CLASS_W'(i)) scan_cnt = cnt_q[i];
    end
  end

  // A strict greater-than keeps the earlier (lower) index on ties.
  assign scan_better = (scan_cnt > best_cnt_q);
  assign scan_last   = (scan_idx_q == CLASS_W'(NUM_CLASSES-1));
  assign final_cls   = scan_better ? scan_idx_q : best_cls_q;
  assign final_cnt   = scan_better ? scan_cnt   : best_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fill_q      <= '0;
      scan_idx_q  <= '0;
      best_cls_q  <= '0;
      best_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_err_q   <= 1'b0;
      for (int i = 0; i < WIN; i++)         win_q[i] <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
    end else if (in_flush) begin
      // Flush outranks any accept or output handshake in the same cycle.
      state_q     <= IDLE;
      fill_q      <= '0;
      scan_idx_q  <= '0;
      best_cls_q  <= '0;
      best_cnt_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < WIN; i++)         win_q[i] <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            win_q[0] <= in_class;
            for (int i = 1; i < WIN; i++) win_q[i] <= win_q[i-1];
            for (int i = 0; i < NUM_CLASSES; i++) begin
              if (inc_hit[i] && !dec_hit[i])      cnt_q[i] <= cnt_q[i] + CNT_W'(1);
              else if (dec_hit[i] && !inc_hit[i]) cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
            if (!full)      fill_q    <= fill_q + CNT_W'(1);
            if (!new_legal) out_err_q <= 1'b1;
            // The window is full after this accept: start a vote.
            if (full || (fill_q == CNT_W'(WIN-1))) begin
              state_q    <= SCAN;
              in_ready_q <= 1'b0;
              scan_idx_q <= '0;
              best_cls_q <= '0;
              best_cnt_q <= '0;
            end
          end
        end
        SCAN: begin
          best_cls_q <= final_cls;
          best_cnt_q <= final_cnt;
          scan_idx_q <= scan_idx_q + CLASS_W'(1);
          if (scan_last) begin
            state_q     <= EMIT;
            out_valid_q <= 1'b1;
            out_class_q <= final_cls;
          end
        end
        EMIT: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DTREE_VOTE_CONF_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      out_votes <= '0;
    else if (!in_flush && (state_q == SCAN) && scan_last)
      out_votes <= final_cnt;
  end
`else
  // No vote-count output register. best_cnt_q still decides the winner.
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_dtree_vote_filter.sv
// -----------------------------------------------------------------------------
// tb_dtree_vote_filter
//
// Directed bench for dtree_vote_filter with default parameters. A window model
// pushes the expected class and votes into a queue whenever a label completes a
// full window. The queue entry is popped and compared when out_valid appears.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Vote counts are checked only when DTREE_VOTE_CONF_EN is defined.
// -----------------------------------------------------------------------------
module tb_dtree_vote_filter;

  localparam int NC  = 10;
  localparam int WIN = 5;
  localparam int CW  = 4;
  localparam int VW  = $clog2(WIN+1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [CW-1:0] in_class;
  logic          in_ready;
  logic          in_flush;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_class;
  logic          out_err;
`ifdef DTREE_VOTE_CONF_EN
  logic [VW-1:0] out_votes;
`endif

  dtree_vote_filter #(.NUM_CLASSES(NC), .WIN(WIN), .CLASS_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_class  (in_class),
    .in_ready  (in_ready),
    .in_flush  (in_flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_err   (out_err)
`ifdef DTREE_VOTE_CONF_EN
    ,
    .out_votes (out_votes)
`endif
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state.
  int            compared   = 0;
  int            mismatched = 0;
  logic [CW-1:0] exp_q  [$];
  logic [VW-1:0] expv_q [$];
  logic [CW-1:0] mwin   [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Window model. It tallies the window contents and picks the winner by a
  // descending sweep with >=, so ties resolve to the lowest class.
  task automatic model_push(input logic [CW-1:0] lbl);
    int            mc [16];
    int            bc;
    logic [CW-1:0] bcls;
    mwin.push_back(lbl);
    if (mwin.size() > WIN) void'(mwin.pop_front());
    if (mwin.size() == WIN) begin
      for (int c = 0; c < 16; c++) mc[c] = 0;
      foreach (mwin[k]) if (mwin[k] < NC) mc[mwin[k]]++;
      bc   = 0;
      bcls = '0;
      for (int c = NC-1; c >= 0; c--) begin
        if (mc[c] >= bc) begin
          bc   = mc[c];
          bcls = CW'(c);
        end
      end
      exp_q.push_back(bcls);
      expv_q.push_back(VW'(bc));
    end
  endtask

  // Driver: waits (bounded) for in_ready, then presents one label for one edge.
  task automatic send(input logic [CW-1:0] lbl);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("send_ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_class = lbl;
    tick();
    in_valid = 1'b0;
    model_push(lbl);
  endtask

  task automatic flush();
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    mwin.delete();
  endtask

  // out_valid must stay low for the given number of cycles.
  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      if (out_valid !== 1'b0) seen++;
      tick();
    end
    chk(tag, seen, 0);
  endtask

  // Called right after the accepting edge. Waits for the result, compares it
  // with the queue head, optionally stalls for hold cycles, then handshakes.
  task automatic collect(input bit chk_lat, input int hold);
    int            lat;
    logic [CW-1:0] e;
    logic [VW-1:0] ev;
    logic [CW-1:0] held;
    lat = 1;
    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
    while (out_valid !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    if (chk_lat) chk("latency", lat, NC + 1);
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ev = expv_q.pop_front();
      chk("out_class", {28'd0, out_class}, {28'd0, e});
`ifdef DTREE_VOTE_CONF_EN
      chk("out_votes", 32'(out_votes), 32'(ev));
`endif
    end else begin
      chk("exp_queue_empty", exp_q.size(), 1);
    end
    held = out_class;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_class = 4'd8;
      tick();
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_class", {28'd0, out_class}, {28'd0, held});
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("post_hs_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_class  = '0;
    in_flush  = 1'b0;
    out_ready = 1'b0;

    // Reset values.
    repeat (3) tick();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_class", {28'd0, out_class}, 32'd0);
    chk("rst_out_err",   {31'd0, out_err},   32'd0);
`ifdef DTREE_VOTE_CONF_EN
    chk("rst_out_votes", 32'(out_votes), 32'd0);
`endif
    rst_n = 1'b1;
    chk("ready_at_release", {31'd0, in_ready}, 32'd0);
    tick();
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Fill with 3s: no output until the window is full, then latency 11.
    for (int i = 0; i < 4; i++) begin
      send(4'd3);
      chk("no_out_early", {31'd0, out_valid}, 32'd0);
    end
    expect_quiet("quiet_partial", 12);
    send(4'd3);
    collect(1'b1, 0);

    // Eviction: 7s replace 3s one at a time.
    for (int i = 0; i < 3; i++) begin
      send(4'd7);
      collect(1'b1, 0);
    end

    // Tie 5,2,5,2,9 -> lowest index (2).
    flush();
    chk("err_clear_before", {31'd0, out_err}, 32'd0);
    send(4'd5); send(4'd2); send(4'd5); send(4'd2); send(4'd9);
    collect(1'b1, 0);

    // Out-of-range labels set the sticky error. The winner comes from legal labels.
    flush();
    send(4'd12);
    chk("err_set", {31'd0, out_err}, 32'd1);
    send(4'd12); send(4'd12); send(4'd1); send(4'd1);
    collect(1'b1, 0);
    flush();
    chk("err_sticky_flush", {31'd0, out_err}, 32'd1);

    // Backpressure: hold EMIT for 20 cycles while pulsing in_valid. Then
    // confirm that no pulse entered the window.
    for (int i = 0; i < 4; i++) send(4'd4);
    send(4'd4);
    collect(1'b1, 20);
    send(4'd4);
    collect(1'b1, 0);

    // Flush mid-SCAN drops the pending result and empties the window.
    send(4'd6);
    repeat (3) tick();
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    mwin.delete();
    void'(exp_q.pop_back());
    void'(expv_q.pop_back());
    chk("flush_idle_ready", {31'd0, in_ready}, 32'd1);
    expect_quiet("quiet_after_flush", 15);
    send(4'd0); send(4'd1); send(4'd0); send(4'd1);
    expect_quiet("quiet_refill", 12);
    send(4'd0);
    collect(1'b1, 0);

    // All labels illegal -> class 0, votes 0.
    flush();
    send(4'd15); send(4'd15); send(4'd11); send(4'd10); send(4'd13);
    collect(1'b1, 0);

    // Random legal labels from an empty window.
    flush();
    for (int i = 0; i < 13; i++) begin
      send(CW'($urandom_range(0, NC-1)));
      if (exp_q.size() != 0) collect(1'b1, 0);
      else chk("rand_no_out", {31'd0, out_valid}, 32'd0);
    end

    // Reset during EMIT aborts the result and clears the sticky error.
    send(4'd2);
    begin
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < 60) begin
        tick();
        n++;
      end
      chk("emit_before_reset", {31'd0, out_valid}, 32'd1);
    end
    rst_n = 1'b0;
    tick();
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, in_ready},  32'd0);
    chk("rst_mid_err",   {31'd0, out_err},   32'd0);
    rst_n = 1'b1;
    mwin.delete();
    exp_q.delete();
    expv_q.delete();
    tick();
    chk("ready_after_rst2", {31'd0, in_ready}, 32'd1);
    expect_quiet("quiet_after_rst2", 12);
    for (int i = 0; i < 4; i++) send(4'd9);
    expect_quiet("quiet_refill2", 12);
    send(4'd9);
    collect(1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
